// File: rtl/fifo_late_reader.sv
// fifo_late_reader: read-side front end for a synchronous FIFO whose rd_data
// and ne update one clock after re. Reads are issued ahead of demand and the
// returning words land in a 3-entry holding buffer that feeds a valid/ready
// stream with frame marking and a delivered-word counter.
module fifo_late_reader #(
  parameter int DATAWIDTH = 18,
  parameter int FRAMELEN  = 0,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] fifo_rd_data,
  input  logic                 fifo_ne,
  output logic                 fifo_re,
  input  logic                 en,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNTWIDTH-1:0]  words
);

  localparam int FW = (FRAMELEN > 1) ? $clog2(FRAMELEN) : 1;
  localparam logic [FW-1:0] FLAST = FW'((FRAMELEN > 0) ? FRAMELEN - 1 : 0);

  logic [DATAWIDTH-1:0] buf_q [3];
  logic [DATAWIDTH-1:0] buf_d [3];
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [CNTWIDTH-1:0]  words_q, words_d;
  logic                 pop;
  logic [1:0]           wpos;

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = buf_q[0];
  assign out_last  = (FRAMELEN != 0) && out_valid && (fcnt_q == FLAST);
  assign words     = words_q;

  // Reads are only issued when a buffer slot is guaranteed for the returning
  // word; out_ready is deliberately kept out of this term.
  assign fifo_re = !reset && en && fifo_ne
                   && (({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd3);

  // Next buffer contents, occupancy, frame position and word count.
  always_comb begin
    buf_d   = buf_q;
    occ_d   = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    fcnt_d  = fcnt_q;
    words_d = words_q;
    wpos    = occ_q - {1'b0, pop};
    if (pop) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
      fcnt_d   = (fcnt_q == FLAST) ? '0 : fcnt_q + 1'b1;
      words_d  = words_q + 1'b1;
    end
    // Capture slot accounts for the shift so the returning word lands right
    // behind whatever survives this cycle's pop.
    if (inflight_q) begin
      case (wpos)
        2'd0:    buf_d[0] = fifo_rd_data;
        2'd1:    buf_d[1] = fifo_rd_data;
        default: buf_d[2] = fifo_rd_data;
      endcase
    end
  end

  // Control state; reset drops any in-flight read so stale rd_data is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      fcnt_q     <= '0;
      words_q    <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_re;
      fcnt_q     <= fcnt_d;
      words_q    <= words_d;
    end
  end

  // Buffer data path; contents are meaningless while occupancy excludes them.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
  end

endmodule

// File: tb/tb_fifo_late_reader.sv
// Testbench for fifo_late_reader: behavioural late-read FIFO, directed
// scenarios, and a scoreboard monitor that checks every accepted word.
module tb_fifo_late_reader;

  localparam int DW = 18;
  localparam int FL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_ne;
  logic          fifo_re;
  logic          en = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [CW-1:0] words;

  always #5 clk = ~clk;

  fifo_late_reader #(.DATAWIDTH(DW), .FRAMELEN(FL), .CNTWIDTH(CW)) dut (
    .clk(clk), .reset(reset), .fifo_rd_data(fifo_rd_data), .fifo_ne(fifo_ne),
    .fifo_re(fifo_re), .en(en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .words(words)
  );

  // Word store shared by the FIFO model (reader) and the scoreboard.
  logic [DW-1:0] mem [0:1023];
  int push_cnt = 0;
  int flush_at = 0;
  int rd_cnt = 0;
  int re_count = 0;
  int pop_count = 0;
  logic underflow = 1'b0;

  assign fifo_ne = (push_cnt != rd_cnt);

  // Late-read FIFO model: data and ne update one clock after re.
  always @(posedge clk) begin
    if (reset) begin
      rd_cnt <= flush_at;
    end else begin
      if (fifo_re) begin
        re_count <= re_count + 1;
        if (push_cnt == rd_cnt) underflow <= 1'b1;
        else begin
          fifo_rd_data <= mem[rd_cnt];
          rd_cnt <= rd_cnt + 1;
        end
      end
      if (out_valid && out_ready) pop_count <= pop_count + 1;
    end
  end

  int vec = 0;
  int err = 0;
  int exp_rd = 0;
  int mfcnt = 0;
  logic [CW-1:0] mwords = '0;
  logic [DW-1:0] last_log [0:255];
  int last_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vec++;
    if (act !== expv) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[push_cnt] = d;
    push_cnt++;
  endtask

  task automatic reset_on();
    reset = 1'b1;
    flush_at = push_cnt;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (exp_rd == push_cnt) break;
      cyc(1);
    end
    chk("drain_timeout", (exp_rd == push_cnt), 1);
    cyc(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus plus forked scoreboard monitor.
  initial begin
    int pb, rb, ln0;
    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          exp_rd = flush_at;
          mfcnt = 0;
          mwords = '0;
        end else begin
          chk("words", words, mwords);
          chk("out_last", out_last, (out_valid && mfcnt == FL - 1));
          if (out_valid) begin
            if (exp_rd == push_cnt) chk("unexpected_valid", out_valid, 0);
            else if (out_ready) begin
              chk("out_data", out_data, mem[exp_rd]);
              if (out_last) begin
                last_log[last_n] = out_data;
                last_n++;
              end
              exp_rd++;
              mfcnt = (mfcnt + 1) % FL;
              mwords = mwords + 1'b1;
            end
          end
        end
      end
    join_none

    // Reset held with a non-empty FIFO, then streaming 0..99.
    en = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    reset_on();
    for (int i = 0; i < 100; i++) push(DW'(i));
    repeat (3) begin
      @(negedge clk);
      chk("rst_fifo_re", fifo_re, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_words", words, 0);
      chk("rst_last", out_last, 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("first_re", fifo_re, 1);
    @(negedge clk);
    chk("lat_valid_n1", out_valid, 0);
    @(negedge clk);
    chk("lat_valid_n2", out_valid, 1);
    chk("lat_data", out_data, 0);
    @(posedge clk);
    #1;
    cyc(98);
    chk("stream_rate", pop_count, 99);
    drain(50);
    chk("stream_words", words, 4);
    chk("stream_re_total", re_count, 100);
    chk("stream_pops", pop_count, 100);
    chk("stream_valid_off", out_valid, 0);

    // Backpressure: 10-cycle stall after six words have gone out.
    reset_on();
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) push(DW'(1000 + i));
    cyc(8);
    out_ready = 1'b0;
    cyc(3);
    repeat (7) begin
      @(negedge clk);
      chk("bp_fifo_re", fifo_re, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", out_data, 1006);
      @(posedge clk);
      #1;
    end
    chk("bp_buffered", re_count - pop_count, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_release_valid", out_valid, 1);
      chk("bp_release_data", out_data, 1006 + i);
    end
    @(posedge clk);
    #1;
    drain(100);

    // Frames with random backpressure.
    reset_on();
    cyc(1);
    reset = 1'b0;
    ln0 = last_n;
    for (int i = 0; i < 12; i++) push(DW'(2000 + i));
    for (int i = 0; i < 300; i++) begin
      if (exp_rd == push_cnt) break;
      out_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    out_ready = 1'b1;
    drain(20);
    chk("frame_last_count", last_n - ln0, 3);
    chk("frame_last0", last_log[ln0], 2003);
    chk("frame_last1", last_log[ln0 + 1], 2007);
    chk("frame_last2", last_log[ln0 + 2], 2011);

    // Reset two words into a frame; frame counting restarts.
    reset_on();
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'(3000 + i));
    cyc(4);
    reset_on();
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_words", words, 0);
    chk("midrst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    ln0 = last_n;
    for (int i = 0; i < 8; i++) push(DW'(4000 + i));
    drain(40);
    chk("midrst_last_count", last_n - ln0, 2);
    chk("midrst_last0", last_log[ln0], 4003);
    chk("midrst_last1", last_log[ln0 + 1], 4007);

    // Enable dropped right after a single read.
    en = 1'b0;
    reset_on();
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) push(DW'(5000 + i));
    cyc(2);
    @(negedge clk);
    chk("en_off_re", fifo_re, 0);
    chk("en_off_valid", out_valid, 0);
    @(posedge clk);
    #1;
    en = 1'b1;
    @(negedge clk);
    chk("en_on_re", fifo_re, 1);
    @(posedge clk);
    #1;
    en = 1'b0;
    pb = pop_count;
    rb = re_count;
    repeat (5) begin
      @(negedge clk);
      chk("en_drop_re", fifo_re, 0);
      @(posedge clk);
      #1;
    end
    chk("en_inflight_out", pop_count - pb, 1);
    chk("en_no_more_re", re_count - rb, 0);
    chk("en_valid_fall", out_valid, 0);
    en = 1'b1;
    drain(40);
    chk("en_resume", pop_count - pb, 10);

    // Counter wrap with the FIFO running dry between bursts.
    reset_on();
    cyc(1);
    reset = 1'b0;
    pb = pop_count;
    for (int i = 0; i < 20; i++) begin
      push(DW'(6000 + i));
      if (i % 4 == 3) cyc(5);
      else cyc(1);
    end
    drain(40);
    chk("wrap_words", words, 4);
    chk("wrap_pops", pop_count - pb, 20);
    chk("underflow", underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
